// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: WIDTH-cycle shift-add multiply or restoring
// divide on operand magnitudes, then one FIX cycle applying sign and exception rules.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_mult_q, is_mult_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0]   mag_a, mag_b, quo_s;
    logic               start;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod, prod_s;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mult_d = is_mult_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        exc_d     = exc_q;

        mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        start = ((state_q == IDLE) || (state_q == DONE)) && (ctrl_MULT || ctrl_DIV);

        // Multiply holds |B| in lo and |A| in opnd; divide holds |A| in lo and |B| in opnd.
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd_q});

        prod   = {acc_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_q : lo_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_mult_d = ctrl_MULT;
                    neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    acc_d     = '0;
                    lo_d      = ctrl_MULT ? mag_b : mag_a;
                    opnd_d    = ctrl_MULT ? mag_a : mag_b;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (is_mult_q) begin
                    acc_d = mul_sum[WIDTH:1];
                    lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    acc_d = div_ok ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], div_ok};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                if (is_mult_q) begin
                    result_d = prod_s[WIDTH-1:0];
                    exc_d    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
                end else if (opnd_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    // A positive quotient with the sign bit set only arises from MIN / -1.
                    result_d = quo_s;
                    exc_d    = !neg_q && lo_q[WIDTH-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (ctrl_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_mult_q <= 1'b0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mult_q <= is_mult_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN) || (state_q == FIX);

endmodule
